// File: rtl/bm_chip_emulator.sv
// Pin-level stand-in for the Bayesian-machine likelihood array chip: CWL-pulsed writes, read_8/read_1 captures, serial readout.
// Optional build macro BM_EMU_PULSE_CHECK_EN: commit on CWL fall, reject pulses shorter than MIN_PULSE, count rejects.
module bm_chip_emulator #(
  parameter int N_QROWS   = 64,
  parameter int N_COLS    = 256,
  parameter int OUT_LAT   = 3,
  parameter int MIN_PULSE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CBL,
  input  logic       CBLEN,
  input  logic       CSL,
  input  logic       CWL,
  input  logic       read_8,
  input  logic       read_1,
  input  logic       read_out,
  input  logic       load_mem,
  input  logic       inference,
  input  logic       load_seed,
  input  logic       stoch_log,
  input  logic [7:0] seeds,
  input  logic [7:0] adr_full_row,
  input  logic [7:0] adr_full_col,
  output logic [3:0] bit_out
`ifdef BM_EMU_PULSE_CHECK_EN
  ,
  output logic [7:0] short_pulse_cnt
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_PULSE = 3'd1;
  localparam logic [2:0] S_RD_PRE   = 3'd2;
  localparam logic [2:0] S_RD_PULSE = 3'd3;
  localparam logic [2:0] S_RD_HOLD  = 3'd4;
  localparam logic [2:0] S_SHIFT    = 3'd5;
  localparam logic [3:0] K_FIRST    = 4'(OUT_LAT);

  logic [2:0]        r_state;
  logic [7:0]        r_row;
  logic [7:0]        r_col;
  logic              r_rd8;
  logic [3:0]        r_k;
  logic [7:0]        r_cap [4];
  logic [N_COLS-1:0] r_mem [4*N_QROWS];

  logic       w_accept;
  logic       w_wr_start;
  logic       w_rd_start;
  logic       w_commit;
  logic [7:0] w_wr_row;
  logic [7:0] w_wr_col;
  logic       w_wr_val;
  logic [7:0] w_cap_nxt [4];
  logic       w_shift_win;
  logic [2:0] w_bit_idx;
  logic       w_unused;

  assign w_unused = ^{inference, load_seed, stoch_log, seeds};

  // RD_HOLD behaves like IDLE for starting new accesses
  assign w_accept   = (r_state == S_IDLE) || (r_state == S_RD_HOLD);
  assign w_wr_start = w_accept & CBLEN & CWL;
  assign w_rd_start = w_accept & ~CBLEN & CWL & CSL & (read_8 | read_1);

`ifdef BM_EMU_PULSE_CHECK_EN
  localparam logic [7:0] MIN_PW = 8'(MIN_PULSE);

  logic [7:0] r_pw;
  logic [7:0] r_short;
  logic       r_cbl;
  logic       r_csl;
  logic       w_wr_end;

  assign w_wr_end = (r_state == S_WR_PULSE) & ~CWL;
  assign w_commit = rst_n & w_wr_end & r_cbl & (r_pw >= MIN_PW);
  assign w_wr_row = r_row;
  assign w_wr_col = r_col;
  assign w_wr_val = r_csl;
  assign short_pulse_cnt = r_short;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pw    <= '0;
      r_short <= '0;
      r_cbl   <= 1'b0;
      r_csl   <= 1'b0;
    end else begin
      if (w_wr_start) begin
        r_pw  <= 8'd1;
        r_cbl <= CBL;
        r_csl <= CSL;
      end else if ((r_state == S_WR_PULSE) && CWL && (r_pw != 8'hFF)) begin
        r_pw <= r_pw + 8'd1;
      end
      if (w_wr_end && (r_pw < MIN_PW) && (r_short != 8'hFF))
        r_short <= r_short + 8'd1;
    end
  end
`else
  // Commit immediately on the write start, from the live pins
  assign w_commit = rst_n & w_wr_start & CBL;
  assign w_wr_row = adr_full_row;
  assign w_wr_col = adr_full_col;
  assign w_wr_val = CSL;
`endif

  always_ff @(posedge clk) begin
    if (w_commit)
      r_mem[w_wr_row][w_wr_col] <= w_wr_val;
  end

  // Quadrant bits of the latched row are replaced by the lane index
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      w_cap_nxt[q] = '0;
      if (r_rd8) begin
        for (int i = 0; i < 8; i++)
          w_cap_nxt[q][i] = r_mem[{2'(q), r_row[5:0]}][{r_col[7:3], 3'(i)}];
      end else begin
        w_cap_nxt[q][0] = r_mem[{2'(q), r_row[5:0]}][r_col];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_rd8   <= 1'b0;
      r_k     <= '0;
      for (int q = 0; q < 4; q++) r_cap[q] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RD_HOLD: begin
          if (w_wr_start) begin
            r_state <= S_WR_PULSE;
            r_row   <= adr_full_row;
            r_col   <= adr_full_col;
          end else if (w_rd_start) begin
            r_state <= S_RD_PRE;
            r_row   <= adr_full_row;
            r_col   <= adr_full_col;
            r_rd8   <= read_8;
          end else if (read_out) begin
            r_state <= S_SHIFT;
            r_k     <= '0;
          end
        end
        S_WR_PULSE: if (!CWL) r_state <= S_IDLE;
        S_RD_PRE: begin
          if (CBLEN || !CWL) r_state <= S_IDLE;
          else if (!CSL)     r_state <= S_RD_PULSE;
        end
        S_RD_PULSE: begin
          if (!CWL) begin
            r_state <= S_RD_HOLD;
            for (int q = 0; q < 4; q++) r_cap[q] <= w_cap_nxt[q];
          end
        end
        S_SHIFT: begin
          if (!read_out) begin
            r_state <= S_IDLE;
            r_k     <= '0;
          end else begin
            if (r_k != 4'hF) r_k <= r_k + 4'd1;
            if (load_mem && !read_8)
              for (int q = 0; q < 4; q++) r_cap[q] <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_shift_win = (r_state == S_SHIFT) && (r_k >= K_FIRST) && (r_k <= 4'd10);
  assign w_bit_idx   = 3'(4'd10 - r_k);

  always_comb begin
    bit_out = '0;
    for (int q = 0; q < 4; q++)
      bit_out[q] = w_shift_win & r_cap[q][w_bit_idx];
  end

endmodule

// File: tb/tb_bm_chip_emulator.sv
// Scoreboarded random bench for bm_chip_emulator; expected serial bits come from a cell/capture model.
module tb_bm_chip_emulator;

  localparam int MIN_PULSE = 2;
  localparam int OUT_LAT   = 3;

  logic       clk = 1'b0;
  logic       rst_n, CBL, CBLEN, CSL, CWL, read_8, read_1, read_out, load_mem;
  logic       inference, load_seed, stoch_log;
  logic [7:0] seeds, adr_full_row, adr_full_col;
  logic [3:0] bit_out;
`ifdef BM_EMU_PULSE_CHECK_EN
  logic [7:0] short_pulse_cnt;
`endif

  bm_chip_emulator dut (
    .clk(clk), .rst_n(rst_n), .CBL(CBL), .CBLEN(CBLEN), .CSL(CSL), .CWL(CWL),
    .read_8(read_8), .read_1(read_1), .read_out(read_out), .load_mem(load_mem),
    .inference(inference), .load_seed(load_seed), .stoch_log(stoch_log),
    .seeds(seeds), .adr_full_row(adr_full_row), .adr_full_col(adr_full_col),
    .bit_out(bit_out)
`ifdef BM_EMU_PULSE_CHECK_EN
    , .short_pulse_cnt(short_pulse_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  bit [255:0] mem_m [256];
  bit [7:0]   cap_m [4];
  int         sp_m = 0;
  logic [3:0] exp_q [$];

  logic samp_ro  = 1'b0;
  logic samp_rst = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    samp_ro  <= read_out;
    samp_rst <= rst_n;
  end

  // Output is only presented in the cycle after read_out was sampled high
  always @(negedge clk) begin
    if (!samp_rst || !samp_ro) begin
      check("bit_out_quiet", {4'b0, bit_out}, 8'h00);
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_underflow: got %0h with no expected entry", bit_out);
    end else begin
      check("bit_out_serial", {4'b0, bit_out}, {4'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_bits(input int k);
    logic [3:0] v;
    v = '0;
    if (k >= OUT_LAT && k <= 10)
      for (int q = 0; q < 4; q++) v[q] = cap_m[q][10 - k];
    return v;
  endfunction

  task automatic do_write(input logic [7:0] row, input logic [7:0] col,
                          input bit csl, input bit cbl, input int p);
    bit commit;
    CBLEN = 1; CWL = 1; CSL = csl; CBL = cbl;
    adr_full_row = row; adr_full_col = col;
    step();
    for (int i = 1; i < p; i++) begin
      adr_full_row = 8'($urandom); adr_full_col = 8'($urandom);
      CSL = 1'($urandom); CBL = 1'($urandom);
      step();
    end
    CWL = 0; CBLEN = 0; CSL = 0; CBL = 0;
    step();
`ifdef BM_EMU_PULSE_CHECK_EN
    commit = (p >= MIN_PULSE);
    if (!commit && sp_m < 255) sp_m++;
`else
    commit = 1'b1;
`endif
    if (commit && cbl) mem_m[row][col] = csl;
  endtask

  task automatic do_read(input logic [7:0] row, input logic [7:0] col,
                         input bit r8, input bit abort_rd);
    int base;
    CBLEN = 0; CWL = 1; CSL = 1; read_8 = r8; read_1 = !r8;
    adr_full_row = row; adr_full_col = col;
    step();
    if (abort_rd) begin
      CWL = 0; CSL = 0;
      step();
    end else begin
      CSL = 0;
      step();
      CWL = 0;
      step();
      for (int q = 0; q < 4; q++) begin
        base = q * 64 + (int'(row) % 64);
        cap_m[q] = 8'h00;
        if (r8) begin
          for (int i = 0; i < 8; i++) cap_m[q][i] = mem_m[base][(int'(col) / 8) * 8 + i];
        end else begin
          cap_m[q][0] = mem_m[base][col];
        end
      end
    end
    read_8 = 0; read_1 = 0;
    step();
  endtask

  // Drive read_out for n cycles; clear_at (>=1) asserts load_mem on that edge
  task automatic shift_cycles(input int n, input int clear_at);
    for (int s = 0; s < n; s++) begin
      if (s == clear_at && s >= 1)
        for (int q = 0; q < 4; q++) cap_m[q] = 8'h00;
      exp_q.push_back(exp_bits(s > 15 ? 15 : s));
      read_out = 1; load_mem = (s == clear_at);
      step();
    end
    load_mem = 0;
  endtask

  task automatic do_readout(input int n, input int clear_at);
    shift_cycles(n, clear_at);
    read_out = 0;
    step();
  endtask

  function automatic logic [7:0] rand_row();
    logic [5:0] qr;
    qr = ($urandom_range(0, 1) == 0) ? 6'h05 : 6'h2A;
    return {2'($urandom_range(0, 3)), qr};
  endfunction

  function automatic logic [7:0] rand_col();
    logic [7:0] g;
    g = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'h20;
    return g + 8'($urandom_range(0, 7));
  endfunction

  logic [7:0] bytes_t3 [4];
  logic [5:0] qrows [2];

  initial begin
    rst_n = 0; CBL = 0; CBLEN = 0; CSL = 0; CWL = 0; read_8 = 0; read_1 = 0;
    read_out = 0; load_mem = 0; inference = 0; load_seed = 0; stoch_log = 0;
    seeds = 8'h00; adr_full_row = 8'h00; adr_full_col = 8'h00;
    bytes_t3[0] = 8'hA5; bytes_t3[1] = 8'h3C; bytes_t3[2] = 8'hFF; bytes_t3[3] = 8'h00;
    qrows[0] = 6'h05; qrows[1] = 6'h2A;
    repeat (3) step();
    rst_n = 1;
    step();
`ifdef BM_EMU_PULSE_CHECK_EN
    check("short_cnt_reset", short_pulse_cnt, 8'h00);
`endif
    // Replay of the reset capture registers must be all zero
    do_readout(12, -1);

    // Bring the cells the bench uses to a known 0
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 4; q++)
        for (int c = 0; c < 8; c++) begin
          do_write({2'(q), qrows[r]}, 8'h10 + 8'(c), 1'b0, 1'b1, MIN_PULSE);
          do_write({2'(q), qrows[r]}, 8'h20 + 8'(c), 1'b0, 1'b1, MIN_PULSE);
        end

    // Single-cell set, then byte read
    do_write(8'h05, 8'h12, 1'b1, 1'b1, 3);
    do_read(8'h05, 8'h10, 1'b1, 1'b0);
    do_readout(12, -1);

    // Reset polarity clears; CBL=0 leaves the cell alone
    do_write(8'h05, 8'h12, 1'b0, 1'b1, 3);
    do_read(8'h05, 8'h10, 1'b1, 1'b0);
    do_readout(12, -1);
    do_write(8'h05, 8'h12, 1'b1, 1'b1, 3);
    do_write(8'h05, 8'h12, 1'b0, 1'b0, 3);
    do_read(8'h05, 8'h10, 1'b1, 1'b0);
    do_readout(12, -1);

    // Four lanes in parallel; quadrant bits of the read address are ignored
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < 8; i++)
        do_write({2'(q), 6'h05}, 8'h20 + 8'(i), bytes_t3[q][i], 1'b1, 2);
    do_read(8'hC5, 8'h23, 1'b1, 1'b0);
    do_readout(12, -1);
    // Long readout exercises k saturation
    do_readout(30, -1);

    do_read(8'h85, 8'h27, 1'b0, 1'b0);
    do_readout(12, -1);

    // Aborted read keeps the previous capture
    do_read(8'h05, 8'h20, 1'b1, 1'b0);
    do_read(8'h2A, 8'h10, 1'b1, 1'b1);
    do_readout(12, -1);
    // load_mem mid-shift clears the capture
    do_readout(12, 5);
    do_readout(12, -1);

    // Reset while shifting at k=5
    do_read(8'h05, 8'h20, 1'b1, 1'b0);
    shift_cycles(6, -1);
    rst_n = 0;
    step();
    for (int q = 0; q < 4; q++) cap_m[q] = 8'h00;
    rst_n = 1; read_out = 0;
    step();
    step();
    do_readout(12, -1);
    do_read(8'h05, 8'h20, 1'b1, 1'b0);
    do_readout(12, -1);

`ifdef BM_EMU_PULSE_CHECK_EN
    do_write(8'h05, 8'h15, 1'b1, 1'b1, 1);
    check("short_cnt_after_1cyc", short_pulse_cnt, 8'(sp_m));
    do_read(8'h05, 8'h10, 1'b1, 1'b0);
    do_readout(12, -1);
    do_write(8'h05, 8'h15, 1'b1, 1'b1, 2);
    do_read(8'h05, 8'h10, 1'b1, 1'b0);
    do_readout(12, -1);
`endif

    for (int n = 0; n < 200; n++) begin
      seeds = 8'($urandom); inference = 1'($urandom);
      load_seed = 1'($urandom); stoch_log = 1'($urandom);
      case ($urandom_range(0, 4))
        0: do_write(rand_row(), rand_col(), 1'($urandom), 1'($urandom), $urandom_range(1, 4));
        1: do_read(rand_row(), rand_col(), 1'b1, 1'b0);
        2: do_read(rand_row(), rand_col(), 1'b0, 1'b0);
        3: do_read(rand_row(), rand_col(), 1'($urandom), 1'b1);
        default: begin
          int len;
          len = $urandom_range(1, 20);
          do_readout(len, ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : -1);
        end
      endcase
    end

    repeat (4) step();
`ifdef BM_EMU_PULSE_CHECK_EN
    check("short_cnt_final", short_pulse_cnt, 8'(sp_m));
`endif
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
